// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the pipeline sequencer
//
// Purpose : state encoding, grouped stage-control bundle and default
//           parameter values used by pipe_ctrl and pipe_perf_cnt.
// Ports   : none (package).
package pipe_pkg;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int FILL_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } pipe_state_t;

  // One bundle for every per-stage load enable and bubble-insert control.
  typedef struct packed {
    logic f_en;
    logic d_en;
    logic x_en;
    logic m_en;
    logic w_en;
    logic d_bubble;
    logic x_bubble;
    logic m_bubble;
    logic w_bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - stall-cycle and flush performance counters
//
// Purpose : two free-running 32-bit event counters that wrap at 2^32.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           stall_inc         - count one front-end stall cycle
//           flush_inc         - count one accepted branch redirect
//           stall_cycles      - stall-cycle count
//           flush_count       - redirect count
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc) flush_count  <= flush_count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central sequencer for the five-stage F/D/X/M/W pipeline
//
// Purpose : merges hazard stalls, memory handshake, branch redirect and halt
//           into per-stage enables/bubbles; owns post-reset fill, memory-wait
//           timeout and the halted state.
// Macro   : PIPE_CTRL_PERF_EN - instantiates pipe_perf_cnt; otherwise the
//           counter ports are tied to zero.
// Ports   : clk, rst_n                           - clock, async active-low reset
//           fd/dx/xm_stall_req                   - hazard stall requests
//           mem_req, mem_ack                     - M-stage memory handshake
//           br_taken                             - D-stage taken branch
//           w_halt                               - halt retiring in W
//           f_en..w_en                           - stage register load enables
//           d_bubble..w_bubble                   - stage loads a NOP instead
//           mw_stall                             - back to the forwarding unit
//           halted, timeout_err                  - sticky status
//           state                                - FSM state for debug
//           stall_cycles, flush_count            - performance counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int FILL_CYCLES = FILL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fd_stall_req,
  input  logic        dx_stall_req,
  input  logic        xm_stall_req,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        br_taken,
  input  logic        w_halt,
  output logic        f_en,
  output logic        d_en,
  output logic        x_en,
  output logic        m_en,
  output logic        w_en,
  output logic        d_bubble,
  output logic        x_bubble,
  output logic        m_bubble,
  output logic        w_bubble,
  output logic        mw_stall,
  output logic        halted,
  output logic        timeout_err,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int             WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [3:0]     FILL_LOAD = 4'(FILL_CYCLES - 1);

  pipe_state_t       state_q;
  logic [3:0]        fill_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halted_q;
  logic              timeout_q;
  stage_ctrl_t       ctrl;
  logic              mw_stall_c;

  // Stage controls are combinational from the registered state and the
  // current inputs. Holding them all low while rst_n is asserted keeps every
  // stage register frozen during reset regardless of state_q.
  always_comb begin
    ctrl       = '0;
    mw_stall_c = 1'b0;
    if (rst_n) begin
      case (state_q)
        FILL: begin
          // PC holds the reset vector while NOPs flush the downstream stages.
          ctrl = '{f_en: 1'b0, d_en: 1'b1, x_en: 1'b1, m_en: 1'b1, w_en: 1'b1,
                   d_bubble: 1'b1, x_bubble: 1'b1, m_bubble: 1'b1, w_bubble: 1'b1};
        end
        RUN: begin
          if (!w_halt && mem_req && !mem_ack) begin
            ctrl.w_en     = 1'b1;
            ctrl.w_bubble = 1'b1;
            mw_stall_c    = 1'b1;
          end else if (!w_halt && xm_stall_req) begin
            ctrl.m_en     = 1'b1;
            ctrl.m_bubble = 1'b1;
            ctrl.w_en     = 1'b1;
          end else if (!w_halt && dx_stall_req) begin
            ctrl.x_en     = 1'b1;
            ctrl.m_en     = 1'b1;
            ctrl.w_en     = 1'b1;
            ctrl.x_bubble = 1'b1;
          end else if (!w_halt && fd_stall_req) begin
            ctrl.d_en     = 1'b1;
            ctrl.x_en     = 1'b1;
            ctrl.m_en     = 1'b1;
            ctrl.w_en     = 1'b1;
            ctrl.d_bubble = 1'b1;
          end else begin
            // Free flow; a halting instruction also retires this way.
            ctrl.f_en     = 1'b1;
            ctrl.d_en     = 1'b1;
            ctrl.x_en     = 1'b1;
            ctrl.m_en     = 1'b1;
            ctrl.w_en     = 1'b1;
            ctrl.d_bubble = br_taken;
          end
        end
        MEMWAIT: begin
          if (mem_ack) begin
            ctrl.f_en = 1'b1;
            ctrl.d_en = 1'b1;
            ctrl.x_en = 1'b1;
            ctrl.m_en = 1'b1;
            ctrl.w_en = 1'b1;
          end else begin
            ctrl.w_en     = 1'b1;
            ctrl.w_bubble = 1'b1;
            mw_stall_c    = 1'b1;
          end
        end
        default: begin
          ctrl       = '0;
          mw_stall_c = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      fill_cnt  <= FILL_LOAD;
      wait_cnt  <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (fill_cnt == 4'd0) state_q <= RUN;
          else                  fill_cnt <= fill_cnt - 4'd1;
        end
        RUN: begin
          if (w_halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (mem_req && !mem_ack) begin
            // The entry cycle is already the first wait cycle.
            state_q  <= MEMWAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        MEMWAIT: begin
          if (mem_ack) begin
            state_q <= RUN;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_q   <= HALTED;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        default: begin
          state_q <= HALTED;
        end
      endcase
    end
  end

  assign f_en        = ctrl.f_en;
  assign d_en        = ctrl.d_en;
  assign x_en        = ctrl.x_en;
  assign m_en        = ctrl.m_en;
  assign w_en        = ctrl.w_en;
  assign d_bubble    = ctrl.d_bubble;
  assign x_bubble    = ctrl.x_bubble;
  assign m_bubble    = ctrl.m_bubble;
  assign w_bubble    = ctrl.w_bubble;
  assign mw_stall    = mw_stall_c;
  assign halted      = halted_q;
  assign timeout_err = timeout_q;
  assign state       = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;

  // A redirect is accepted only on a free-flowing RUN cycle, which is exactly
  // when f_en is high in RUN; frozen-D cycles drop br_taken.
  assign stall_inc = ((state_q == RUN) || (state_q == MEMWAIT)) && !ctrl.f_en;
  assign flush_inc = (state_q == RUN) && ctrl.f_en && br_taken;

  pipe_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc    (stall_inc),
    .flush_inc    (flush_inc),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
